// File: rtl/ser_pkg.sv
// Shared types and helpers for the serializer arbiter.
// Holds the FSM state encoding and the illegal-mod rule.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    ISSUE_S = 2'd1,
    WAIT_S  = 2'd2
  } state_e;

  localparam int unsigned ILL_MOD_A = 1;
  localparam int unsigned ILL_MOD_B = 2;

  function automatic logic is_illegal_mod(
    input int unsigned m
  );
    return (m == ILL_MOD_A) || (m == ILL_MOD_B);
  endfunction

endpackage

// File: rtl/ser_arbiter_if.sv
// Requester and serializer side bundle of the arbiter.
// slave = arbiter view, master = environment view.
interface ser_arbiter_if #(
  parameter int N_REQ          = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
);
  localparam int IW = $clog2(N_REQ);

  logic                                     en_i;
  logic [N_REQ-1:0]                         req_i;
  logic [N_REQ-1:0][DATA_BUS_WIDTH-1:0]     req_data_i;
  logic [N_REQ-1:0][DATA_MOD_WIDTH-1:0]     req_mod_i;
  logic [N_REQ-1:0]                         ack_o;
  logic [N_REQ-1:0]                         drop_o;
  logic [DATA_BUS_WIDTH-1:0]                ser_data_o;
  logic [DATA_MOD_WIDTH-1:0]                ser_data_mod_o;
  logic                                     ser_data_val_o;
  logic                                     ser_busy_i;
  logic [IW-1:0]                            grant_id_o;
  logic                                     busy_o;

  modport slave (
    input  en_i, req_i, req_data_i, req_mod_i,
    input  ser_busy_i,
    output ack_o, drop_o, ser_data_o,
    output ser_data_mod_o, ser_data_val_o,
    output grant_id_o, busy_o
  );

  modport master (
    output en_i, req_i, req_data_i, req_mod_i,
    output ser_busy_i,
    input  ack_o, drop_o, ser_data_o,
    input  ser_data_mod_o, ser_data_val_o,
    input  grant_id_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr_i,
// wrapping past N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int c;

  // Scan upward from the pointer, keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = (int'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// Arbitrates N requesters onto one serializer, dropping
// words whose mod is 1 or 2 and issuing the rest.
module ser_arbiter
  import ser_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input logic          clk_i,
  input logic          srst_i,
  ser_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = DATA_BUS_WIDTH;
  localparam int MW = DATA_MOD_WIDTH;

  state_e           state_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    grant_id_q;
  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] drop_q;
  logic             val_q;
  logic [DW-1:0]    data_q;
  logic [MW-1:0]    mod_q;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic [IW-1:0]    next_ptr;
  logic             win_ill;

  // A requester sees its drop one cycle late, so mask it
  // that cycle to avoid dropping the same word twice.
  assign req_eff = bus.req_i & ~drop_q;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req_i (req_eff),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign next_ptr = (win_idx == IW'(N_REQ - 1))
                  ? '0 : win_idx + IW'(1);
  assign win_ill  =
    is_illegal_mod(32'(bus.req_mod_i[win_idx]));

  // Single FSM: select, drop or latch, issue, wait.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE_S;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      drop_q     <= '0;
      val_q      <= 1'b0;
      data_q     <= '0;
      mod_q      <= '0;
    end else begin
      ack_q  <= '0;
      drop_q <= '0;
      val_q  <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (bus.en_i && win_any && !bus.ser_busy_i) begin
            rr_ptr_q   <= next_ptr;
            grant_id_q <= win_idx;
            if (win_ill) begin
              drop_q <= gnt;
            end else begin
              ack_q   <= gnt;
              val_q   <= 1'b1;
              data_q  <= bus.req_data_i[win_idx];
              mod_q   <= bus.req_mod_i[win_idx];
              state_q <= ISSUE_S;
            end
          end
        end
        ISSUE_S: state_q <= WAIT_S;
        WAIT_S: begin
          if (!bus.ser_busy_i) state_q <= IDLE_S;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign bus.ack_o          = ack_q;
  assign bus.drop_o         = drop_q;
  assign bus.ser_data_val_o = val_q;
  assign bus.ser_data_o     = data_q;
  assign bus.ser_data_mod_o = mod_q;
  assign bus.grant_id_o     = grant_id_q;
  assign bus.busy_o         = (state_q != IDLE_S);

endmodule
